// File: rtl/mux4x1_mux2x1.sv
// Four-input select built from a two-level 2:1 mux tree, with an optional output register.
// Latency 1 cycle when REG_OUT=1, 0 when REG_OUT=0; no backpressure, every in_valid cycle is taken.

// Single 2:1 mux leaf, one per tree node.
module mux2x1 #(
   parameter int WIDTH = 1
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_sel,
   output logic [WIDTH-1:0] o_y
);
   assign o_y = i_sel ? i_b : i_a;
endmodule

module mux4x1_mux2x1 #(
   parameter int WIDTH   = 1,
   parameter int REG_OUT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] i0,
   input  logic [WIDTH-1:0] i1,
   input  logic [WIDTH-1:0] i2,
   input  logic [WIDTH-1:0] i3,
   input  logic             s0,
   input  logic             s1,
   input  logic             in_valid,
   output logic [WIDTH-1:0] out_comb,
   output logic [WIDTH-1:0] out,
   output logic             out_valid
);
   logic [WIDTH-1:0] w_m_lo;
   logic [WIDTH-1:0] w_m_hi;
   logic [WIDTH-1:0] w_tree;
   logic [WIDTH-1:0] r_out;
   logic             r_out_valid;

   mux2x1 #(.WIDTH(WIDTH)) u_lvl1_lo (.i_a(i0),     .i_b(i1),     .i_sel(s0), .o_y(w_m_lo));
   mux2x1 #(.WIDTH(WIDTH)) u_lvl1_hi (.i_a(i2),     .i_b(i3),     .i_sel(s0), .o_y(w_m_hi));
   mux2x1 #(.WIDTH(WIDTH)) u_lvl2    (.i_a(w_m_lo), .i_b(w_m_hi), .i_sel(s1), .o_y(w_tree));

   assign out_comb = w_tree;

   // Data holds while in_valid is low; only the valid flag drops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out       <= '0;
         r_out_valid <= 1'b0;
      end else begin
         if (in_valid) begin
            r_out <= w_tree;
         end
         r_out_valid <= in_valid;
      end
   end

   // With REG_OUT=0 the registers are left dangling and trimmed by synthesis.
   assign out       = (REG_OUT != 0) ? r_out       : w_tree;
   assign out_valid = (REG_OUT != 0) ? r_out_valid : in_valid;
endmodule

// File: tb/tb_mux4x1_mux2x1.sv
// Bench for mux4x1_mux2x1: directed scenarios plus randomized traffic against a select-array model.
module tb_mux4x1_mux2x1;
   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] din [4];
   logic       s0, s1, in_valid;

   logic [7:0] r8_comb, r8_out;
   logic       r8_vld;
   logic       r1_comb, r1_out, r1_vld;
   logic [7:0] c8_comb, c8_out;
   logic       c8_vld;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mux4x1_mux2x1 #(.WIDTH(8), .REG_OUT(1)) u_reg8 (
      .clk(clk), .rst_n(rst_n), .i0(din[0]), .i1(din[1]), .i2(din[2]), .i3(din[3]),
      .s0(s0), .s1(s1), .in_valid(in_valid),
      .out_comb(r8_comb), .out(r8_out), .out_valid(r8_vld));

   mux4x1_mux2x1 #(.WIDTH(1), .REG_OUT(1)) u_reg1 (
      .clk(clk), .rst_n(rst_n), .i0(din[0][0]), .i1(din[1][0]), .i2(din[2][0]), .i3(din[3][0]),
      .s0(s0), .s1(s1), .in_valid(in_valid),
      .out_comb(r1_comb), .out(r1_out), .out_valid(r1_vld));

   mux4x1_mux2x1 #(.WIDTH(8), .REG_OUT(0)) u_comb8 (
      .clk(clk), .rst_n(rst_n), .i0(din[0]), .i1(din[1]), .i2(din[2]), .i3(din[3]),
      .s0(s0), .s1(s1), .in_valid(in_valid),
      .out_comb(c8_comb), .out(c8_out), .out_valid(c8_vld));

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: the selected input is simply din[select code]; registered copy captured on valid edges.
   logic [7:0] m_out = 8'h00;
   logic       m_vld = 1'b0;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_out <= 8'h00;
         m_vld <= 1'b0;
      end else begin
         if (in_valid) m_out <= din[{s1, s0}];
         m_vld <= in_valid;
      end
   end

   always @(negedge clk) begin
      logic [7:0] sel;
      sel = din[{s1, s0}];
      chk("reg8_out_comb",  r8_comb, sel);
      chk("reg8_out",       r8_out, m_out);
      chk("reg8_out_valid", {7'b0, r8_vld}, {7'b0, m_vld});
      chk("reg1_out_comb",  {7'b0, r1_comb}, {7'b0, sel[0]});
      chk("reg1_out",       {7'b0, r1_out}, {7'b0, m_out[0]});
      chk("reg1_out_valid", {7'b0, r1_vld}, {7'b0, m_vld});
      chk("comb8_out",      c8_out, sel);
      chk("comb8_out_comb", c8_comb, sel);
      chk("comb8_out_valid", {7'b0, c8_vld}, {7'b0, in_valid});
   end

   task automatic drive(input logic [7:0] d0, d1, d2, d3, input logic [1:0] sel, input logic vld);
      din[0] = d0; din[1] = d1; din[2] = d2; din[3] = d3;
      {s1, s0} = sel;
      in_valid = vld;
   endtask

   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   logic [7:0] exp_seq [4];

   initial begin
      rst_n = 1'b0;
      drive(8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 1'b0);
      #1;
      chk("reset_out",       r8_out, 8'h00);
      chk("reset_out_valid", {7'b0, r8_vld}, 8'h00);
      tick; tick;
      rst_n = 1'b1;

      // One-hot walk: combinational paths settle with no edge, registered ones after one edge.
      for (int k = 0; k < 4; k++) begin
         drive(8'h00, 8'h00, 8'h00, 8'h00, k[1:0], 1'b1);
         din[k] = 8'h01;
         #1;
         chk("walk_comb8_out",  c8_out, 8'h01);
         chk("walk_comb8_vld",  {7'b0, c8_vld}, 8'h01);
         chk("walk_reg1_comb",  {7'b0, r1_comb}, 8'h01);
         tick;
         chk("walk_reg1_out",   {7'b0, r1_out}, 8'h01);
         chk("walk_reg1_vld",   {7'b0, r1_vld}, 8'h01);
      end

      // Only the selected input is zero; everything else is all ones.
      for (int k = 0; k < 4; k++) begin
         drive(8'hFF, 8'hFF, 8'hFF, 8'hFF, k[1:0], 1'b1);
         din[k] = 8'h00;
         #1;
         chk("iso_out_comb", r8_comb, 8'h00);
         tick;
         chk("iso_out", r8_out, 8'h00);
      end

      exp_seq[0] = 8'hA5; exp_seq[1] = 8'h3C; exp_seq[2] = 8'hF0; exp_seq[3] = 8'h0F;
      for (int k = 0; k < 4; k++) begin
         drive(8'hA5, 8'h3C, 8'hF0, 8'h0F, k[1:0], 1'b1);
         tick;
         chk("sel8_out", r8_out, exp_seq[k]);
      end

      // Valid gating: out holds the captured value while out_comb keeps tracking.
      drive(8'hA5, 8'h3C, 8'hF0, 8'h0F, 2'b01, 1'b1);
      tick;
      chk("gate_capture", r8_out, 8'h3C);
      drive(8'h11, 8'h22, 8'h33, 8'h44, 2'b11, 1'b0);
      #1;
      chk("gate_comb_track", r8_comb, 8'h44);
      tick;
      chk("gate_hold", r8_out, 8'h3C);
      chk("gate_valid_low", {7'b0, r8_vld}, 8'h00);
      drive(8'h55, 8'h66, 8'h77, 8'h88, 2'b10, 1'b0);
      tick;
      chk("gate_hold2", r8_out, 8'h3C);
      chk("gate_comb_track2", r8_comb, 8'h77);

      // Asynchronous reset between edges, then recapture.
      drive(8'hA5, 8'h3C, 8'hF0, 8'h0F, 2'b10, 1'b1);
      tick;
      chk("arst_pre_out", r8_out, 8'hF0);
      chk("arst_pre_vld", {7'b0, r8_vld}, 8'h01);
      rst_n = 1'b0;
      #1;
      chk("arst_out",      r8_out, 8'h00);
      chk("arst_vld",      {7'b0, r8_vld}, 8'h00);
      chk("arst_comb_vld", {7'b0, c8_vld}, 8'h01);
      tick;
      chk("arst_held_out", r8_out, 8'h00);
      rst_n = 1'b1;
      tick;
      chk("arst_recapture", r8_out, 8'hF0);
      chk("arst_recap_vld", {7'b0, r8_vld}, 8'h01);

      // Randomized traffic with occasional reset pulses; the negedge compare does the checking.
      for (int n = 0; n < 400; n++) begin
         drive(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
               2'($urandom_range(0, 3)), ($urandom_range(0, 9) < 7));
         if (!rst_n) rst_n = 1'b1;
         else if ($urandom_range(0, 31) == 0) rst_n = 1'b0;
         tick;
      end
      rst_n = 1'b1;
      tick; tick;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
